// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// one bit per clock, with a start/busy/done handshake.
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_M1  = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic             carry_msb;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_next;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    s_bit    = fa_sum(a_sr[0], b_sr[0], carry);
    c_next   = fa_carry(a_sr[0], b_sr[0], carry);
    res_next = {s_bit, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      cnt       <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_sum     <= '0;
      o_cout    <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // Subtraction is A + ~B + 1: invert B at capture and seed the carry.
          if (i_start) begin
            a_sr   <= i_a;
            b_sr   <= i_mode ? ~i_b : i_b;
            carry  <= i_mode ? 1'b1 : i_cin;
            cnt    <= '0;
            state  <= SHIFT;
            o_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= c_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_M1) begin
            carry_msb <= c_next;
          end
          if (cnt == LAST) begin
            o_sum  <= res_next;
            o_cout <= c_next;
            o_ovf  <= carry_msb ^ c_next;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Scoreboard bench for serial_adder_sub at WIDTH=8: expected results are queued
// at issue time and compared whenever o_done pulses.
module tb_serial_adder_sub;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done_cyc = 0;
  int busy_cnt = 0;
  int start_cyc = 0;
  exp_t sb[$];

  serial_adder_sub #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_mode  (mode),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout),
    .o_ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic m, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic c);
    exp_t         e;
    logic [W:0]   r;
    logic [W-1:0] yy;
    yy = m ? ~y : y;
    if (!m) r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    else    r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    return e;
  endfunction

  // Output monitor: compare against the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      exp_t e;
      done_count++;
      last_done_cyc = cyc;
      check("busy_done_excl", {63'd0, busy}, 64'd0);
      check("busy_cycles", busy_cnt, W);
      busy_cnt = 0;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("ovf", ovf, e.ovf);
      end
    end
  end

  task automatic issue(input logic m, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic c, input bit expect_result);
    mode = m; a = x; b = y; cin = c; start = 1'b1;
    if (expect_result) sb.push_back(model(m, x, y, c));
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int k = 0;
    while (done_count == n0 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_count == n0) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic m, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic c);
    int n0;
    n0 = done_count;
    issue(m, x, y, c, 1'b1);
    wait_done(n0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int first_done;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_done", {63'd0, done}, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", {63'd0, cout}, 0);
    check("rst_ovf", {63'd0, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    n0 = done_count;
    issue(1'b0, 8'h0F, 8'h01, 1'b0, 1'b1);
    wait_done(n0);
    check("latency", last_done_cyc - start_cyc, W);
    @(negedge clk);
    #1;

    run_op(1'b0, 8'hFF, 8'h01, 1'b0);
    run_op(1'b0, 8'h7F, 8'h00, 1'b1);
    run_op(1'b1, 8'h05, 8'h07, 1'b0);
    run_op(1'b1, 8'h80, 8'h01, 1'b0);
    run_op(1'b1, 8'h10, 8'h10, 1'b1);

    // Second start and operand changes during SHIFT must be ignored.
    n0 = done_count;
    issue(1'b0, 8'h10, 8'h20, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; mode = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n0);
    repeat (12) @(negedge clk);
    #1;
    check("single_done", done_count - n0, 1);

    // Back-to-back issue: start held high through the DONE cycle.
    n0 = done_count;
    issue(1'b0, 8'h22, 8'h11, 1'b0, 1'b1);
    mode = 1'b0; a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    sb.push_back(model(1'b0, 8'h01, 8'h01, 1'b0));
    wait_done(n0);
    first_done = last_done_cyc;
    n0 = done_count;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n0);
    check("b2b_spacing", last_done_cyc - first_done, W + 1);
    @(negedge clk);
    #1;

    // Reset in the 4th SHIFT cycle discards the operation.
    n0 = done_count;
    issue(1'b0, 8'h55, 8'h22, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy_cnt = 0;
    check("mid_rst_busy", {63'd0, busy}, 0);
    check("mid_rst_done", {63'd0, done}, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", {63'd0, cout}, 0);
    check("mid_rst_ovf", {63'd0, ovf}, 0);
    repeat (12) @(negedge clk);
    #1;
    check("mid_rst_no_done", done_count - n0, 0);

    run_op(1'b0, 8'h33, 8'h11, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_sub.md
Name: serial_adder_sub

Overview:
Bit-serial adder/subtractor, parametrised in operand width. It reuses a single full-adder cell and a carry flop, and processes one bit per clock, LSB first. It is the sequential, width-generic successor to the combinational half/full adder cells. It sits behind the universal bench as the first clocked arithmetic DUT, and uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst_n  input  1  synchronous active-low reset, sampled on the i_clk rising edge.
i_start  input  1  request a new operation; sampled only in IDLE or DONE.
i_mode  input  1  0 = add (A + B + i_cin), 1 = subtract (A - B).
i_a  input  WIDTH  operand A, captured when i_start is accepted.
i_b  input  WIDTH  operand B, captured when i_start is accepted.
i_cin  input  1  carry-in for add mode; ignored in subtract mode.
o_busy  output  1  high while bits are being shifted (SHIFT state).
o_done  output  1  single-cycle completion pulse.
o_sum  output  WIDTH  result; holds its value until the next completion.
o_cout  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
o_ovf  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - State goes to IDLE.
  - o_busy, o_done, o_cout and o_ovf go to 0; o_sum goes to 0.
  - Internal operand shift registers, carry flop and bit counter are cleared.
  - Reset wins over every other input, including reset asserted mid-SHIFT. The partial result is discarded and no o_done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If i_start = 1 at an edge: capture A = i_a and B' = (i_mode ? ~i_b : i_b).
  - Carry flop is loaded with (i_mode ? 1 : i_cin), mode is latched, counter is set to 0, state goes to SHIFT.
  - Otherwise the state stays IDLE.
- SHIFT:
  - Each edge computes s = A[0]^B'[0]^c and c_next = majority(A[0], B'[0], c).
  - s is shifted into the result register from the MSB side. A and B' shift right by one. The carry flop takes c_next and the counter increments.
  - On the edge that processes bit WIDTH-2, the carry into the MSB is saved for overflow detection.
  - On the edge that processes bit WIDTH-1 (counter = WIDTH-1), the following update:
    - o_sum = the completed result register;
    - o_cout = c_next;
    - o_ovf = saved carry-into-MSB XOR c_next;
    - state goes to DONE.
  - i_start is ignored in SHIFT. Operands and mode are not re-sampled.
- DONE:
  - o_done = 1 for exactly this one cycle.
  - If i_start = 1 at this edge, a new operation is accepted exactly as from IDLE (back-to-back issue); otherwise the state goes to IDLE.
- Latency: the start edge is T0. Bits are processed at edges T1..TWIDTH. o_done is high in the cycle after TWIDTH. Throughput is one operation per WIDTH+1 cycles.
- o_busy = 1 exactly while the state is SHIFT. o_busy and o_done are never high together.
- Arithmetic is modulo 2^WIDTH. Inputs changing during SHIFT have no effect on the result.

Test Plan:
- WIDTH=8, reset for 2 cycles, then add 8'h0F + 8'h01 with cin=0 -> o_done pulses 8 cycles after the start edge; o_sum=8'h10, cout=0, ovf=0; o_busy high for exactly 8 cycles.
- Add 8'hFF + 8'h01 (cin=0) -> 8'h00, cout=1, ovf=0. Add 8'h7F + 8'h00 with cin=1 -> 8'h80, cout=0, ovf=1.
- Subtract 8'h05 - 8'h07 -> 8'hFE, cout=0 (borrow), ovf=0. Subtract 8'h80 - 8'h01 -> 8'h7F, cout=1, ovf=1.
- Pulse i_start again and change i_a/i_b in the 3rd SHIFT cycle of 8'h10 + 8'h20 -> the second start is ignored; result 8'h30 with a single o_done.
- Hold i_start high through DONE with a new op 8'h01 + 8'h01 -> the second op starts at the DONE edge; the second o_done comes 9 cycles after the first; o_sum=8'h02.
- Assert i_rst_n=0 for 1 cycle during the 4th SHIFT cycle -> all outputs are 0 on the next cycle, no o_done, state IDLE. A following start of 8'h33 + 8'h11 completes normally with 8'h44.
